// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: arbiter state encoding,
// requester index names and SRAM bus widths.
package sram_arbiter_pkg;

  // Arbiter states, kept alongside the top-level state definitions
  typedef enum logic [1:0] {
    S_ARB_IDLE  = 2'd0,
    S_ARB_GRANT = 2'd1,
    S_ARB_TURN  = 2'd2
  } arb_state_e;

  // Requester indices (bit positions in req/grant/rd_valid)
  localparam int REQ_M1 = 0;
  localparam int REQ_M2 = 1;
  localparam int REQ_M3 = 2;

  // SRAM bus widths
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

endpackage : sram_arbiter_pkg

// File: rtl/sram_arbiter_if.sv
// Requester/SRAM-side bus of the arbiter. The per-requester end-of-burst
// pulse is named burst_release because "release" is a reserved word.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] burst_release;
  logic [ADDR_W-1:0]  req_address    [NUM_REQ];
  logic [DATA_W-1:0]  req_write_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_we_n;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rd_valid;
  logic [ADDR_W-1:0]  SRAM_address;
  logic [DATA_W-1:0]  SRAM_write_data;
  logic               SRAM_we_n;
  logic [1:0]         arb_state;

  // Requester side (milestone blocks / testbench)
  modport master (
    output req, burst_release, req_address, req_write_data, req_we_n,
    input  grant, rd_valid, SRAM_address, SRAM_write_data, SRAM_we_n, arb_state
  );

  // Arbiter side
  modport slave (
    input  req, burst_release, req_address, req_write_data, req_we_n,
    output grant, rd_valid, SRAM_address, SRAM_write_data, SRAM_we_n, arb_state
  );

endinterface : sram_arbiter_if

// File: rtl/sram_arbiter_rr_priority_select.sv
// Combinational round-robin winner: searches req starting one past
// last_owner and wrapping modulo NUM_REQ; the first set bit wins.
module rr_priority_select #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               winner_valid
);

  // Scan candidates last_owner+1 .. last_owner+NUM_REQ, reduced modulo NUM_REQ
  always_comb begin
    logic [IDX_W:0] cand_s;
    winner       = {IDX_W{1'b0}};
    winner_valid = 1'b0;
    cand_s       = {(IDX_W+1){1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      // last_owner <= NUM_REQ-1 and i <= NUM_REQ, so one subtraction wraps
      cand_s = {1'b0, last_owner} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!winner_valid && req[cand_s[IDX_W-1:0]]) begin
        winner       = cand_s[IDX_W-1:0];
        winner_valid = 1'b1;
      end else begin
        winner       = winner;
        winner_valid = winner_valid;
      end
    end
  end

endmodule : rr_priority_select

// File: rtl/sram_arbiter.sv
// Round-robin SRAM bus arbiter. One owner at a time forwards commands to the
// SRAM controller; a one-cycle turnaround separates owners so the read
// pipeline drains. Read tags ride an RD_LAT-deep shift register so rd_valid
// reaches the requester that issued the read even after the grant moved on.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int RD_LAT  = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  sram_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   last_owner_r;
  logic [ADDR_W-1:0]  addr_hold_r;
  logic [NUM_REQ-1:0] rd_pipe_r [RD_LAT];

  logic [IDX_W-1:0]   winner_s;
  logic               winner_valid_s;
  logic [NUM_REQ-1:0] winner_onehot_s;
  logic [NUM_REQ-1:0] owner_onehot_s;
  logic               in_grant_s;
  logic               release_s;
  logic               rd_push_s;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req          (bus.req),
    .last_owner   (last_owner_r),
    .winner       (winner_s),
    .winner_valid (winner_valid_s)
  );

  // Index-to-one-hot decode for the new winner and the current owner
  always_comb begin
    winner_onehot_s = {NUM_REQ{1'b0}};
    owner_onehot_s  = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      winner_onehot_s[k] = (winner_s == IDX_W'(k));
      owner_onehot_s[k]  = (owner_r == IDX_W'(k));
    end
  end

  // Owner's end of burst (own pulse or request dropped) and read tag push
  always_comb begin
    in_grant_s = (state_r == S_ARB_GRANT);
    release_s  = in_grant_s && (bus.burst_release[owner_r] || !bus.req[owner_r]);
    rd_push_s  = in_grant_s && bus.req_we_n[owner_r];
  end

  // SRAM command mux: owner's command passes straight through while granted
  always_comb begin
    if (in_grant_s) begin
      bus.SRAM_address    = bus.req_address[owner_r];
      bus.SRAM_write_data = bus.req_write_data[owner_r];
      bus.SRAM_we_n       = bus.req_we_n[owner_r];
    end else begin
      bus.SRAM_address    = addr_hold_r;
      bus.SRAM_write_data = {DATA_W{1'b0}};
      bus.SRAM_we_n       = 1'b1;
    end
  end

  // Arbitration FSM: idle -> grant (held until release) -> one turnaround cycle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r      <= S_ARB_IDLE;
      grant_r      <= {NUM_REQ{1'b0}};
      owner_r      <= {IDX_W{1'b0}};
      last_owner_r <= LAST_IDX;
      addr_hold_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        S_ARB_IDLE: begin
          if (winner_valid_s) begin
            grant_r <= winner_onehot_s;
            owner_r <= winner_s;
            state_r <= S_ARB_GRANT;
          end else begin
            grant_r <= {NUM_REQ{1'b0}};
          end
        end
        S_ARB_GRANT: begin
          addr_hold_r <= bus.req_address[owner_r];
          if (release_s) begin
            grant_r      <= {NUM_REQ{1'b0}};
            last_owner_r <= owner_r;
            state_r      <= S_ARB_TURN;
          end else begin
            grant_r <= owner_onehot_s;
          end
        end
        S_ARB_TURN: begin
          grant_r <= {NUM_REQ{1'b0}};
          state_r <= S_ARB_IDLE;
        end
        default: begin
          grant_r <= {NUM_REQ{1'b0}};
          state_r <= S_ARB_IDLE;
        end
      endcase
    end
  end

  // Read-tag pipeline: one-hot tag of the reading owner, "no valid" for writes
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < RD_LAT; k++) begin
        rd_pipe_r[k] <= {NUM_REQ{1'b0}};
      end
    end else begin
      rd_pipe_r[0] <= rd_push_s ? owner_onehot_s : {NUM_REQ{1'b0}};
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe_r[k] <= rd_pipe_r[k-1];
      end
    end
  end

  assign bus.grant     = grant_r;
  assign bus.rd_valid  = rd_pipe_r[RD_LAT-1];
  assign bus.arb_state = state_r;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int LAT = 2;

  logic Clock;
  logic Resetn;

  sram_arbiter_if #(.NUM_REQ(N)) bus ();

  sram_arbiter #(.NUM_REQ(N), .RD_LAT(LAT)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  // Model: owner index (-1 none), turnaround flag, last owner, held address,
  // and expected rd_valid per absolute cycle number
  int          m_owner;
  int          m_turn;
  int          m_last;
  logic [17:0] m_addr;
  logic [N-1:0] exp_rd [0:8191];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_turn  = 0;
    m_last  = N - 1;
    m_addr  = 18'd0;
    for (int i = 0; i < 8192; i++) exp_rd[i] = '0;
  endtask

  // Effect of the cycle that just ended (inputs still on the bus)
  task automatic model_advance();
    int c;
    if (m_owner >= 0) begin
      if (bus.req_we_n[m_owner]) exp_rd[cyc + LAT] = exp_rd[cyc + LAT] | (3'b001 << m_owner);
      m_addr = bus.req_address[m_owner];
      if (bus.burst_release[m_owner] || !bus.req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_turn  = 1;
      end
    end else if (m_turn != 0) begin
      m_turn = 0;
    end else begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (bus.req[c]) begin
          m_owner = c;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0]  e_grant;
    logic [17:0] e_addr;
    logic [15:0] e_data;
    logic        e_we;
    logic [1:0]  e_state;
    if (m_owner >= 0) begin
      e_grant = 3'b001 << m_owner;
      e_addr  = bus.req_address[m_owner];
      e_data  = bus.req_write_data[m_owner];
      e_we    = bus.req_we_n[m_owner];
      e_state = S_ARB_GRANT;
    end else begin
      e_grant = 3'b000;
      e_addr  = m_addr;
      e_data  = 16'h0000;
      e_we    = 1'b1;
      e_state = (m_turn != 0) ? S_ARB_TURN : S_ARB_IDLE;
    end
    check_val("grant", bus.grant, e_grant);
    check_val("rd_valid", bus.rd_valid, exp_rd[cyc]);
    check_val("arb_state", bus.arb_state, e_state);
    check_val("we_n", bus.SRAM_we_n, e_we);
    check_val("addr", bus.SRAM_address, e_addr);
    check_val("wdata", bus.SRAM_write_data, e_data);
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Resetn) model_advance();
    cyc++;
    #2;
  endtask

  task automatic apply(input logic [2:0] r, input logic [2:0] rl, input logic [2:0] we,
                       input logic [17:0] a0, input logic [17:0] a1, input logic [17:0] a2,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    bus.req               = r;
    bus.burst_release     = rl;
    bus.req_we_n          = we;
    bus.req_address[0]    = a0;
    bus.req_address[1]    = a1;
    bus.req_address[2]    = a2;
    bus.req_write_data[0] = d0;
    bus.req_write_data[1] = d1;
    bus.req_write_data[2] = d2;
  endtask

  task automatic apply_rnd(input logic [2:0] r, input logic [2:0] rl, input logic [2:0] we);
    apply(r, rl, we, 18'($urandom), 18'($urandom), 18'($urandom),
          16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic sample();
    #2;
    check_outputs();
  endtask

  // Asynchronous reset between clock edges, held across two edges
  task automatic async_reset();
    #1;
    Resetn = 1'b0;
    #1;
    model_reset();
    check_val("rst_grant", bus.grant, 3'b000);
    check_val("rst_rd_valid", bus.rd_valid, 3'b000);
    check_val("rst_state", bus.arb_state, S_ARB_IDLE);
    check_val("rst_we_n", bus.SRAM_we_n, 1'b1);
    check_val("rst_addr", bus.SRAM_address, 18'd0);
    check_val("rst_wdata", bus.SRAM_write_data, 16'h0000);
    apply(3'b000, 3'b000, 3'b111, 18'd0, 18'd0, 18'd0, 16'h0, 16'h0, 16'h0);
    repeat (2) begin
      @(posedge Clock);
      cyc++;
    end
    #5;
    Resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rd_seen;
    int gcnt;
    logic [2:0] prev_grant;
    logic [2:0] gq[$];
    logic [2:0] req_lvl;
    logic [2:0] rl;

    Resetn = 1'b0;
    model_reset();
    apply(3'b000, 3'b000, 3'b111, 18'd0, 18'd0, 18'd0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge Clock);
    #5;
    check_outputs();
    Resetn = 1'b1;

    // M1 reads addresses 0..3, releasing on the fourth command
    tick(); apply(3'b001, 3'b000, 3'b111, 18'd0, 18'd100, 18'd200, 16'h0, 16'h0, 16'h0); sample();
    check_val("s34_no_grant_yet", bus.grant, 3'b000);
    rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      apply(3'b001, (i == 3) ? 3'b001 : 3'b000, 3'b111, 18'(i), 18'd100, 18'd200, 16'h0, 16'h0, 16'h0);
      sample();
      check_val("s34_grant", bus.grant, 3'b001);
      check_val("s34_addr", bus.SRAM_address, 18'(i));
      if (bus.rd_valid[REQ_M1]) rd_seen++;
    end
    for (int i = 0; i < 6; i++) begin
      tick(); apply(3'b000, 3'b000, 3'b111, 18'd0, 18'd0, 18'd0, 16'h0, 16'h0, 16'h0); sample();
      if (bus.rd_valid[REQ_M1]) rd_seen++;
    end
    check_val("s34_rd_count", 32'(rd_seen), 32'd4);

    // All three request; each owner releases after two commands
    async_reset();
    gcnt = 0;
    prev_grant = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_owner >= 0) gcnt++;
      else gcnt = 0;
      apply_rnd(3'b111, (gcnt == 2) ? 3'b111 : 3'b000, 3'b111);
      sample();
      if (bus.grant != 3'b000 && prev_grant == 3'b000) gq.push_back(bus.grant);
      prev_grant = bus.grant;
    end
    check_val("s35_grant_count", 32'(gq.size() >= 4), 32'd1);
    check_val("s35_order0", gq[0], 3'b001);
    check_val("s35_order1", gq[1], 3'b010);
    check_val("s35_order2", gq[2], 3'b100);
    check_val("s35_order3", gq[3], 3'b001);

    // M2 writes 16'hABCD to 27647 while M3 waits for the turnaround
    async_reset();
    tick(); apply(3'b110, 3'b000, 3'b101, 18'd0, 18'd27647, 18'd5000, 16'h0, 16'hABCD, 16'h1234); sample();
    check_val("s36_idle_grant", bus.grant, 3'b000);
    tick(); apply(3'b110, 3'b010, 3'b101, 18'd0, 18'd27647, 18'd5000, 16'h0, 16'hABCD, 16'h1234); sample();
    check_val("s36_grant_m2", bus.grant, 3'b010);
    check_val("s36_we_n", bus.SRAM_we_n, 1'b0);
    check_val("s36_addr", bus.SRAM_address, 18'd27647);
    check_val("s36_wdata", bus.SRAM_write_data, 16'hABCD);
    tick(); apply(3'b100, 3'b000, 3'b101, 18'd0, 18'd27647, 18'd5000, 16'h0, 16'hABCD, 16'h1234); sample();
    check_val("s36_turn_state", bus.arb_state, S_ARB_TURN);
    check_val("s36_turn_we_n", bus.SRAM_we_n, 1'b1);
    check_val("s36_turn_addr_hold", bus.SRAM_address, 18'd27647);
    tick(); apply(3'b100, 3'b000, 3'b101, 18'd0, 18'd27647, 18'd5000, 16'h0, 16'hABCD, 16'h1234); sample();
    check_val("s36_idle_grant2", bus.grant, 3'b000);
    tick(); apply(3'b100, 3'b000, 3'b101, 18'd0, 18'd27647, 18'd5000, 16'h0, 16'hABCD, 16'h1234); sample();
    check_val("s36_grant_m3", bus.grant, 3'b100);
    check_val("s36_m3_addr", bus.SRAM_address, 18'd5000);

    // M3 drops req; M1 then reads in its release cycle while M2 waits
    tick(); apply_rnd(3'b011, 3'b000, 3'b101); sample();
    tick(); apply_rnd(3'b011, 3'b000, 3'b101); sample();
    tick(); apply_rnd(3'b011, 3'b000, 3'b101); sample();
    tick(); apply_rnd(3'b011, 3'b001, 3'b101); sample();
    check_val("s37_grant_m1", bus.grant, 3'b001);
    tick(); apply_rnd(3'b010, 3'b000, 3'b101); sample();
    tick(); apply_rnd(3'b010, 3'b000, 3'b101); sample();
    check_val("s37_rd_m1", bus.rd_valid, 3'b001);
    check_val("s37_rd_grant", bus.grant, 3'b000);
    check_val("s37_rd_state", bus.arb_state, S_ARB_IDLE);
    tick(); apply_rnd(3'b010, 3'b000, 3'b101); sample();
    check_val("s37_grant_m2", bus.grant, 3'b010);
    check_val("s37_no_rd_m2a", bus.rd_valid, 3'b000);
    tick(); apply_rnd(3'b010, 3'b000, 3'b101); sample();
    check_val("s37_no_rd_m2b", bus.rd_valid, 3'b000);
    repeat (4) begin
      tick(); apply_rnd(3'b000, 3'b000, 3'b111); sample();
    end

    // Reset mid-burst with reads in flight
    async_reset();
    tick(); apply_rnd(3'b001, 3'b000, 3'b111); sample();
    tick(); apply_rnd(3'b001, 3'b000, 3'b111); sample();
    tick(); apply_rnd(3'b001, 3'b000, 3'b111); sample();
    tick(); apply_rnd(3'b001, 3'b000, 3'b111); sample();
    check_val("s38_rd_before_rst", bus.rd_valid, 3'b001);
    async_reset();
    tick(); apply_rnd(3'b100, 3'b000, 3'b111); sample();
    check_val("s38_no_rd0", bus.rd_valid, 3'b000);
    tick(); apply_rnd(3'b100, 3'b000, 3'b111); sample();
    check_val("s38_grant_m3", bus.grant, 3'b100);
    check_val("s38_no_rd1", bus.rd_valid, 3'b000);
    tick(); apply_rnd(3'b000, 3'b000, 3'b000); sample();
    check_val("s38_no_rd2", bus.rd_valid, 3'b000);

    // Non-owner release pulses are ignored
    async_reset();
    tick(); apply_rnd(3'b001, 3'b100, 3'b111); sample();
    for (int i = 0; i < 5; i++) begin
      tick(); apply_rnd(3'b001, 3'b100, 3'b111); sample();
      check_val("s39_hold_m1", bus.grant, 3'b001);
    end
    tick(); apply_rnd(3'b001, 3'b001, 3'b111); sample();
    tick(); apply_rnd(3'b000, 3'b000, 3'b111); sample();
    check_val("s39_released", bus.grant, 3'b000);

    // Randomized traffic with occasional asynchronous resets
    req_lvl = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7, 0) == 0) req_lvl[k] = ~req_lvl[k];
      end
      for (int k = 0; k < N; k++) rl[k] = ($urandom_range(4, 0) == 0);
      apply_rnd(req_lvl, rl, 3'($urandom));
      sample();
      if (i % 400 == 399) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_sram_arbiter
